// File: rtl/video_timing_gen_if.sv
// Video timing bundle shared by the raster generator, the game core and the
// video output stage. The generator sits on the master side: it receives the
// pixel clock-enable, picture shift and core colour, and produces the raster
// coordinates, blank/sync and gated colour.
interface video_timing_gen_if #(
  parameter int POS_W = 9,
  parameter int RGB_W = 8
);
  logic             pix_ce;
  logic [3:0]       h_shift;
  logic [2:0]       v_shift;
  logic [RGB_W-1:0] rgb_in;
  logic [POS_W-1:0] hpos;
  logic [POS_W-1:0] vpos;
  logic [RGB_W-1:0] rgb_out;
  logic             hblank;
  logic             vblank;
  logic             hsync;
  logic             vsync;
  logic             vbl_stb;

  modport master (
    input  pix_ce, h_shift, v_shift, rgb_in,
    output hpos, vpos, rgb_out, hblank, vblank, hsync, vsync, vbl_stb
  );

  modport slave (
    output pix_ce, h_shift, v_shift, rgb_in,
    input  hpos, vpos, rgb_out, hblank, vblank, hsync, vsync, vbl_stb
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// Counts pixels/lines on pix_ce, exposes look-ahead coordinates for the game
// core and registers blank, sync, gated colour and a vertical-blank strobe.
// Optional feature macro VTG_SHIFT_EN: when defined, the signed picture shift
// inputs are latched at frame start and move the sync windows; when undefined
// the shift is fixed at zero and no shift registers exist.

// Elaboration-time guard on the geometry: the porch minimums keep sync clear
// of the active region for every shift value, and the totals must fit the
// counter width.
module video_timing_gen_param_chk #(
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 38,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 58,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 7,
  parameter int V_BP     = 29,
  parameter int POS_W    = 9
) ();
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_FP < 9) begin : g_chk_h_fp
    $fatal(1, "video_timing_gen: H_FP must be >= 9");
  end
  if (H_BP < 9) begin : g_chk_h_bp
    $fatal(1, "video_timing_gen: H_BP must be >= 9");
  end
  if (V_FP < 3) begin : g_chk_v_fp
    $fatal(1, "video_timing_gen: V_FP must be >= 3");
  end
  if (V_BP < 4) begin : g_chk_v_bp
    $fatal(1, "video_timing_gen: V_BP must be >= 4");
  end
  if (H_TOTAL > (1 << POS_W)) begin : g_chk_h_total
    $fatal(1, "video_timing_gen: H_TOTAL does not fit in POS_W bits");
  end
  if (V_TOTAL > (1 << POS_W)) begin : g_chk_v_total
    $fatal(1, "video_timing_gen: V_TOTAL does not fit in POS_W bits");
  end
endmodule

module video_timing_gen #(
  parameter int H_ACTIVE  = 256,
  parameter int H_FP      = 38,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 58,
  parameter int V_ACTIVE  = 224,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 7,
  parameter int V_BP      = 29,
  parameter int HPOS_LEAD = 16,
  parameter int POS_W     = 9,
  parameter int RGB_W     = 8,
  parameter int SYNC_POL  = 0
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  video_timing_gen_if.master    vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Window arithmetic is done two bits wider than the counters so that a
  // shifted window edge (up to total + 8) never wraps.
  localparam int CW = POS_W + 2;

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_ACT    = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_ACT    = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] H_LEAD   = POS_W'(HPOS_LEAD);
  localparam logic [CW-1:0]    HS_BASE  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]    VS_BASE  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]    HS_LEN   = CW'(H_SYNC);
  localparam logic [CW-1:0]    VS_LEN   = CW'(V_SYNC);
  localparam logic             SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  video_timing_gen_param_chk #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .POS_W    (POS_W)
  ) u_param_chk ();

  logic [POS_W-1:0] hcnt_r;
  logic [POS_W-1:0] vcnt_r;
  logic [POS_W-1:0] hcnt_nxt_s;
  logic [POS_W-1:0] vcnt_nxt_s;
  logic             h_last_s;
  logic             v_last_s;
  logic [3:0]       hs_eff_s;
  logic [2:0]       vs_eff_s;
  logic [CW-1:0]    hcnt_x_s;
  logic [CW-1:0]    vcnt_x_s;
  logic [CW-1:0]    hs_lo_s;
  logic [CW-1:0]    hs_hi_s;
  logic [CW-1:0]    vs_lo_s;
  logic [CW-1:0]    vs_hi_s;
  logic             hs_match_s;
  logic             vs_match_s;
  logic             hblank_s;
  logic             vblank_s;
  logic             hblank_r;
  logic             vblank_r;
  logic             hsync_r;
  logic             vsync_r;
  logic [RGB_W-1:0] rgb_r;
  logic             vbl_stb_r;

  assign h_last_s = (hcnt_r == H_LAST);
  assign v_last_s = (vcnt_r == V_LAST);

  // Next raster position: step one pixel, wrap the line and then the frame.
  always_comb begin
    hcnt_nxt_s = hcnt_r + POS_W'(1);
    vcnt_nxt_s = vcnt_r;
    if (h_last_s) begin
      hcnt_nxt_s = {POS_W{1'b0}};
      if (v_last_s) begin
        vcnt_nxt_s = {POS_W{1'b0}};
      end else begin
        vcnt_nxt_s = vcnt_r + POS_W'(1);
      end
    end else begin
      vcnt_nxt_s = vcnt_r;
    end
  end

  // Raster counters advance only on pixel clock-enables.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r <= {POS_W{1'b0}};
      vcnt_r <= {POS_W{1'b0}};
    end else if (vif.pix_ce) begin
      hcnt_r <= hcnt_nxt_s;
      vcnt_r <= vcnt_nxt_s;
    end
  end

`ifdef VTG_SHIFT_EN
  logic [3:0] hs_eff_r;
  logic [2:0] vs_eff_r;

  // Latch the picture shift only as the frame wraps so a frame never tears.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_eff_r <= 4'd0;
      vs_eff_r <= 3'd0;
    end else if (vif.pix_ce && h_last_s && v_last_s) begin
      hs_eff_r <= vif.h_shift;
      vs_eff_r <= vif.v_shift;
    end
  end

  assign hs_eff_s = hs_eff_r;
  assign vs_eff_s = vs_eff_r;
`else
  logic unused_shift_s;

  assign hs_eff_s       = 4'd0;
  assign vs_eff_s       = 3'd0;
  assign unused_shift_s = ^{vif.h_shift, vif.v_shift};
`endif

  // Sync windows start earlier for a positive shift, which moves the picture
  // right/down relative to sync. The shift is sign-extended into the wide
  // domain; the porch minimums keep every edge positive.
  assign hcnt_x_s = {2'b00, hcnt_r};
  assign vcnt_x_s = {2'b00, vcnt_r};
  assign hs_lo_s  = HS_BASE - {{(CW-4){hs_eff_s[3]}}, hs_eff_s};
  assign vs_lo_s  = VS_BASE - {{(CW-3){vs_eff_s[2]}}, vs_eff_s};
  assign hs_hi_s  = hs_lo_s + HS_LEN;
  assign vs_hi_s  = vs_lo_s + VS_LEN;

  assign hs_match_s = (hcnt_x_s >= hs_lo_s) && (hcnt_x_s < hs_hi_s);
  assign vs_match_s = (vcnt_x_s >= vs_lo_s) && (vcnt_x_s < vs_hi_s);
  assign hblank_s   = (hcnt_r >= H_ACT);
  assign vblank_s   = (vcnt_r >= V_ACT);

  // Output stage: blank, sync and gated colour from the pre-increment
  // position; the strobe marks the clock right after vblank rises.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hblank_r  <= 1'b1;
      vblank_r  <= 1'b1;
      hsync_r   <= ~SYNC_ACT;
      vsync_r   <= ~SYNC_ACT;
      rgb_r     <= {RGB_W{1'b0}};
      vbl_stb_r <= 1'b0;
    end else begin
      vbl_stb_r <= vif.pix_ce & vblank_s & ~vblank_r;
      if (vif.pix_ce) begin
        hblank_r <= hblank_s;
        vblank_r <= vblank_s;
        hsync_r  <= hs_match_s ^ ~SYNC_ACT;
        vsync_r  <= vs_match_s ^ ~SYNC_ACT;
        rgb_r    <= (hblank_s || vblank_s) ? {RGB_W{1'b0}} : vif.rgb_in;
      end
    end
  end

  assign vif.hpos    = hcnt_r + H_LEAD;
  assign vif.vpos    = vcnt_r;
  assign vif.hblank  = hblank_r;
  assign vif.vblank  = vblank_r;
  assign vif.hsync   = hsync_r;
  assign vif.vsync   = vsync_r;
  assign vif.rgb_out = rgb_r;
  assign vif.vbl_stb = vbl_stb_r;

endmodule
